// File: rtl/fft_pkg.sv
// fft_pkg
//   Shared constants and types for the FFT datapath stages.
//   SAMPLE_W      : packed complex sample width (re in upper half, im in lower)
//   FFT_MAX_DEPTH : largest delay any stage's delay line must support
//   depth_t       : delay-depth value, wide enough to hold FFT_MAX_DEPTH itself
package fft_pkg;

    localparam int SAMPLE_W      = 32;
    localparam int FFT_MAX_DEPTH = 64;
    localparam int FFT_DEPTH_W   = $clog2(FFT_MAX_DEPTH) + 1;

    typedef logic [FFT_DEPTH_W-1:0] depth_t;

endpackage

// File: rtl/fft_delay_mem.sv
// fft_delay_mem
//   Storage for the programmable delay line: DEPTH x WIDTH register array with
//   one synchronous write port and one asynchronous read port. Kept separate so
//   it can be replaced by a RAM macro with the same port shape.
//   Contents are intentionally not reset; the owner masks stale words.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (combinational read)
//   rdata  out  read data
module fft_delay_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_var_delay.sv
// fft_var_delay
//   Valid-gated, run-time programmable delay line of 1..MAX_DEPTH stages.
//   Behaves like a D-stage shift register that only advances on accepted
//   samples: the edge accepting sample n loads data_out with sample n-(D-1).
//   Storage is a circular buffer; a fill counter hides words written before
//   the last reset / flush / depth load.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   in_valid   in   accept data_in this cycle
//   data_in    in   input sample
//   cfg_load   in   pulse: load (clamped) depth_sel and flush the line
//   depth_sel  in   requested depth, sampled on cfg_load
//   flush      in   pulse: discard line contents, keep depth
//   data_out   out  delayed sample (registered)
//   out_valid  out  one-cycle pulse per emitted sample
//   depth      out  active depth
module fft_var_delay
    import fft_pkg::*;
#(
    parameter int WIDTH     = SAMPLE_W,
    parameter int MAX_DEPTH = FFT_MAX_DEPTH,
    parameter int RST_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               data_in,
    input  logic                           cfg_load,
    input  logic [$clog2(MAX_DEPTH):0]     depth_sel,
    input  logic                           flush,
    output logic [WIDTH-1:0]               data_out,
    output logic                           out_valid,
    output logic [$clog2(MAX_DEPTH):0]     depth
);

    localparam int AW = $clog2(MAX_DEPTH);
    localparam int DW = AW + 1;

    logic [DW-1:0]    depth_q;
    logic [DW-1:0]    fill_q;
    logic [AW-1:0]    wr_ptr;

    logic [DW-1:0]    load_depth;
    logic [DW-1:0]    d_eff;
    logic [DW-1:0]    d_m1;
    logic [DW-1:0]    fill_base;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] delayed;

    // Clamp the requested depth into 1..MAX_DEPTH.
    always_comb begin
        load_depth = depth_sel;
        if (depth_sel == '0) begin
            load_depth = DW'(1);
        end else if (depth_sel > DW'(MAX_DEPTH)) begin
            load_depth = DW'(MAX_DEPTH);
        end
    end

    // A load or flush in the same cycle as an accept takes effect first, so
    // the accepted sample is judged against the new depth and an empty line.
    assign d_eff     = cfg_load ? load_depth : depth_q;
    assign d_m1      = d_eff - DW'(1);
    assign fill_base = (cfg_load || flush) ? '0 : fill_q;

    // Sample n-(D-1) sits D-1 slots behind the slot sample n is written to.
    // For D=MAX_DEPTH the offset truncates correctly to wr_ptr+1.
    assign rd_idx = wr_ptr - d_m1[AW-1:0];

    // D=1 reads the slot being written this cycle, so bypass the array.
    assign delayed = (d_m1 == '0) ? data_in : rd_data;

    fft_delay_mem #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (in_valid),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            depth_q   <= DW'(RST_DEPTH);
            fill_q    <= '0;
            wr_ptr    <= '0;
        end else begin
            if (cfg_load) begin
                depth_q <= load_depth;
            end
            if (in_valid) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (fill_base == d_m1) begin
                    // Line full: emit, fill stays saturated at D-1.
                    out_valid <= 1'b1;
                    data_out  <= delayed;
                    fill_q    <= fill_base;
                end else begin
                    out_valid <= 1'b0;
                    fill_q    <= fill_base + DW'(1);
                end
            end else begin
                out_valid <= 1'b0;
                fill_q    <= fill_base;
            end
        end
    end

    assign depth = depth_q;

endmodule

// File: tb/tb_fft_var_delay.sv
module tb_fft_var_delay;
    import fft_pkg::*;

    localparam int W  = SAMPLE_W;
    localparam int MD = FFT_MAX_DEPTH;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         cfg_load = 1'b0;
    depth_t       depth_sel = '0;
    logic         flush = 1'b0;
    logic [W-1:0] data_out;
    logic         out_valid;
    depth_t       depth;

    int checks = 0;
    int errors = 0;

    fft_var_delay #(.WIDTH(W), .MAX_DEPTH(MD), .RST_DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .cfg_load  (cfg_load),
        .depth_sel (depth_sel),
        .flush     (flush),
        .data_out  (data_out),
        .out_valid (out_valid),
        .depth     (depth)
    );

    always #5 clk = ~clk;

    // Drive one cycle, let the edge happen, then release the pulse inputs.
    task automatic step(input logic v, input logic [W-1:0] d);
        in_valid = v;
        data_in  = d;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cfg_load = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(1'b0, '0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov got %0d exp 0", out_valid); end
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL reset_do got %0h exp 0", data_out); end
        checks++;
        if (depth !== depth_t'(8)) begin errors++; $display("FAIL reset_depth got %0d exp 8", depth); end
    endtask

    task automatic test_default_stream;
        for (int n = 1; n <= 20; n++) begin
            step(1'b1, W'(n));
            checks++;
            if (out_valid !== (n >= 8)) begin
                errors++; $display("FAIL dflt_ov n=%0d got %0d exp %0d", n, out_valid, n >= 8);
            end
            checks++;
            if (data_out !== ((n >= 8) ? W'(n - 7) : W'(0))) begin
                errors++; $display("FAIL dflt_do n=%0d got %0d exp %0d", n, data_out, (n >= 8) ? n - 7 : 0);
            end
        end
    endtask

    task automatic test_gated;
        logic         pat [8];
        logic [W-1:0] dat [8];
        logic         eov [8];
        logic [W-1:0] edo [8];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        dat = '{W'('hA), W'(0), W'('hB), W'('hC), W'(0), W'(0), W'('hD), W'('hE)};
        eov = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        edo = '{W'(0), W'(0), W'(0), W'(0), W'(0), W'(0), W'('hA), W'('hB)};
        rst = 1'b1;
        step(1'b0, '0);
        cfg_load = 1'b1; depth_sel = depth_t'(4);
        step(1'b0, '0);
        checks++;
        if (depth !== depth_t'(4)) begin errors++; $display("FAIL gated_depth got %0d exp 4", depth); end
        for (int i = 0; i < 8; i++) begin
            step(pat[i], dat[i]);
            checks++;
            if (out_valid !== eov[i]) begin
                errors++; $display("FAIL gated_ov i=%0d got %0d exp %0d", i, out_valid, eov[i]);
            end
            checks++;
            if (data_out !== edo[i]) begin
                errors++; $display("FAIL gated_do i=%0d got %0h exp %0h", i, data_out, edo[i]);
            end
        end
        step(1'b0, '0);
        checks++;
        if (out_valid !== 1'b0 || data_out !== W'('hB)) begin
            errors++; $display("FAIL gated_hold got ov=%0d do=%0h exp ov=0 do=b", out_valid, data_out);
        end
    endtask

    task automatic test_reprogram;
        rst = 1'b1;
        step(1'b0, '0);
        for (int i = 1; i <= 10; i++) step(1'b1, W'(100 + i));
        checks++;
        if (out_valid !== 1'b1 || data_out !== W'(103)) begin
            errors++; $display("FAIL reprog_pre got ov=%0d do=%0d exp ov=1 do=103", out_valid, data_out);
        end
        cfg_load = 1'b1; depth_sel = depth_t'(3);
        step(1'b1, W'(200));
        checks++;
        if (depth !== depth_t'(3)) begin errors++; $display("FAIL reprog_depth got %0d exp 3", depth); end
        checks++;
        if (out_valid !== 1'b0 || data_out !== W'(103)) begin
            errors++; $display("FAIL reprog_load got ov=%0d do=%0d exp ov=0 do=103", out_valid, data_out);
        end
        step(1'b1, W'(201));
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reprog_stale got ov=%0d do=%0d exp ov=0", out_valid, data_out); end
        for (int j = 0; j < 4; j++) begin
            step(1'b1, W'(202 + j));
            checks++;
            if (out_valid !== 1'b1 || data_out !== W'(200 + j)) begin
                errors++; $display("FAIL reprog_out j=%0d got ov=%0d do=%0d exp ov=1 do=%0d", j, out_valid, data_out, 200 + j);
            end
        end
    endtask

    task automatic test_clamp;
        cfg_load = 1'b1; depth_sel = depth_t'(0);
        step(1'b1, W'(300));
        checks++;
        if (depth !== depth_t'(1)) begin errors++; $display("FAIL clamp0_depth got %0d exp 1", depth); end
        checks++;
        if (out_valid !== 1'b1 || data_out !== W'(300)) begin
            errors++; $display("FAIL clamp0_out got ov=%0d do=%0d exp ov=1 do=300", out_valid, data_out);
        end
        step(1'b1, W'(301));
        checks++;
        if (out_valid !== 1'b1 || data_out !== W'(301)) begin
            errors++; $display("FAIL d1_out got ov=%0d do=%0d exp ov=1 do=301", out_valid, data_out);
        end
        step(1'b0, W'(999));
        checks++;
        if (out_valid !== 1'b0 || data_out !== W'(301)) begin
            errors++; $display("FAIL d1_hold got ov=%0d do=%0d exp ov=0 do=301", out_valid, data_out);
        end
        cfg_load = 1'b1; depth_sel = depth_t'(MD + 5);
        step(1'b0, '0);
        checks++;
        if (depth !== depth_t'(MD)) begin errors++; $display("FAIL clampmax_depth got %0d exp %0d", depth, MD); end
        for (int i = 0; i < 3 * MD; i++) begin
            step(1'b1, W'(1000 + i));
            checks++;
            if (out_valid !== (i >= MD - 1)) begin
                errors++; $display("FAIL wrap_ov i=%0d got %0d exp %0d", i, out_valid, i >= MD - 1);
            end
            if (i >= MD - 1) begin
                checks++;
                if (data_out !== W'(1000 + i - (MD - 1))) begin
                    errors++; $display("FAIL wrap_do i=%0d got %0d exp %0d", i, data_out, 1000 + i - (MD - 1));
                end
            end
        end
    endtask

    task automatic test_flush_reset;
        cfg_load = 1'b1; depth_sel = depth_t'(16);
        step(1'b0, '0);
        for (int i = 0; i < 20; i++) step(1'b1, W'(2000 + i));
        checks++;
        if (out_valid !== 1'b1 || data_out !== W'(2004)) begin
            errors++; $display("FAIL flush_pre got ov=%0d do=%0d exp ov=1 do=2004", out_valid, data_out);
        end
        flush = 1'b1;
        step(1'b0, '0);
        checks++;
        if (out_valid !== 1'b0 || depth !== depth_t'(16)) begin
            errors++; $display("FAIL flush_now got ov=%0d depth=%0d exp ov=0 depth=16", out_valid, depth);
        end
        for (int j = 0; j < 15; j++) begin
            step(1'b1, W'(3000 + j));
            checks++;
            if (out_valid !== 1'b0 || data_out !== W'(2004)) begin
                errors++; $display("FAIL flush_mask j=%0d got ov=%0d do=%0d exp ov=0 do=2004", j, out_valid, data_out);
            end
        end
        step(1'b1, W'(3015));
        checks++;
        if (out_valid !== 1'b1 || data_out !== W'(3000)) begin
            errors++; $display("FAIL flush_first got ov=%0d do=%0d exp ov=1 do=3000", out_valid, data_out);
        end
        checks++;
        if (depth !== depth_t'(16)) begin errors++; $display("FAIL flush_depth got %0d exp 16", depth); end
        rst = 1'b1;
        step(1'b1, W'(3016));
        checks++;
        if (out_valid !== 1'b0 || data_out !== '0 || depth !== depth_t'(8)) begin
            errors++; $display("FAIL rst_mid got ov=%0d do=%0d depth=%0d exp ov=0 do=0 depth=8", out_valid, data_out, depth);
        end
        for (int j = 0; j < 8; j++) begin
            step(1'b1, W'(4000 + j));
            checks++;
            if (out_valid !== (j == 7) || data_out !== ((j == 7) ? W'(4000) : W'(0))) begin
                errors++; $display("FAIL rst_refill j=%0d got ov=%0d do=%0d exp ov=%0d do=%0d", j, out_valid, data_out, j == 7, (j == 7) ? 4000 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_stream();
        test_gated();
        test_reprogram();
        test_clamp();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_var_delay.md
# fft_var_delay

Parametrised, run-time programmable delay line for the FFT datapath. It generalises the fixed 8-stage register delay into a valid-gated line of 1..MAX_DEPTH stages. The line advances only on accepted samples, and the depth can be reprogrammed between frames with an explicit flush. It sits in the butterfly/commutator path of SDF-style FFT stages, where each stage needs a different delay (N/2, N/4, …, 1) from one block.

## Interface
- WIDTH, 32: sample width in bits (packed complex, re in [WIDTH-1:WIDTH/2], im in [WIDTH/2-1:0]; treated as opaque).
- MAX_DEPTH, 64: maximum delay in samples; power of two, ≥ 2.
- RST_DEPTH, 8: depth loaded at reset; 1..MAX_DEPTH.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample on data_in is accepted this cycle.
- data_in  in  WIDTH  input sample.
- cfg_load  in  1  one-cycle pulse: load depth_sel and flush the line.
- depth_sel  in  $clog2(MAX_DEPTH)+1  requested depth D; sampled only when cfg_load=1.
- flush  in  1  one-cycle pulse: discard line contents, keep current depth.
- data_out  out  WIDTH  delayed sample, registered.
- out_valid  out  1  data_out updated this cycle (one pulse per emitted sample).
- depth  out  $clog2(MAX_DEPTH)+1  currently active depth D.

## Operation
- Semantics match a gated D-stage shift register. The edge that accepts sample n loads data_out with sample n-(D-1). D=1 is a single register: sample n appears on the next cycle.
- fill counter tracks samples accepted since reset, flush or load. It saturates at D-1.
- On an accept with fill = D-1: out_valid<=1 and data_out<=the delayed sample. With fill < D-1: out_valid<=0, data_out holds, fill increments.
- No accept: out_valid<=0, data_out holds, storage and pointers unchanged.
- Storage is a circular buffer of MAX_DEPTH words.
  - wr_ptr increments modulo MAX_DEPTH on each accept.
  - Read index = wr_ptr-(D-1) mod MAX_DEPTH, combinational read.
  - Wrap-around is natural from the power-of-two pointer width.
- depth_sel clamping at load: 0 becomes 1; values > MAX_DEPTH become MAX_DEPTH.
- flush and cfg_load both clear fill and out_valid. Storage contents are not cleared; fill masks them.
- Priority: rst > cfg_load > flush > data path.
- cfg_load or flush in the same cycle as in_valid: the flush/load takes effect first, and the sample is accepted as the first sample of the new line (fill<=1).
  - If the new D=1, that sample is emitted on the next cycle with out_valid=1.
- Reset values: data_out=0, out_valid=0, depth=RST_DEPTH, fill=0, wr_ptr=0. Storage is not reset.
- rst asserted mid-stream: the next cycle shows out_valid=0 and data_out=0. The first output after reset needs D fresh accepts.

## Timing
- Latency: a sample accepted at edge k (with D-1 later accepts) is visible on data_out after the edge of its D-1-th successor accept.
- With continuous in_valid, the latency is exactly D cycles from data_in to data_out. After fill, the line sustains 1 sample/cycle.
- depth is valid the cycle after cfg_load.
- No backpressure: there is no ready. The consumer must take out_valid pulses as they come.
- Single clock domain; every output is a flop.

## Structure
- Shared package fft_pkg: SAMPLE_W (32), FFT_MAX_DEPTH, and a depth_t typedef sized $clog2(MAX_DEPTH)+1. All FFT stages use these.
- One natural sub-module, fft_delay_mem: the MAX_DEPTH×WIDTH register array with one write port and one asynchronous read port, so it can later be swapped for a RAM macro.
- Top level holds the pointers, fill counter, depth register, clamping and output registers.

## Test plan
- Reset/default: rst then continuous in_valid with data_in = 1, 2, 3, … (D=RST_DEPTH=8).
  - out_valid first rises 8 cycles after the first accept, with data_out=1.
  - Then 2, 3, … every cycle.
  - data_out=0 before that.
- Gated input: D=4, in_valid pattern 1,0,1,1,0,0,1,1 carrying A..E.
  - out_valid pulses only on the cycles after accepts once 3 prior samples are held: A after the D accept, B after the E accept.
  - data_out holds between pulses.
- Reprogram: stream at D=8, then cfg_load with depth_sel=3 together with in_valid.
  - depth=3 next cycle.
  - That sample is emitted after 2 further accepts.
  - No stale pre-load sample ever appears.
- Clamping/boundary: depth_sel=0 gives depth=1 with single-cycle delay. depth_sel=MAX_DEPTH+5 gives depth=MAX_DEPTH.
  - Stream 3×MAX_DEPTH samples to exercise pointer wrap.
  - Every output equals input minus MAX_DEPTH-1 accepts.
- Flush/reset mid-stream: flush during a stream at D=16 gives out_valid=0 for the next 15 accepts with depth unchanged.
  - Repeat with rst: depth returns to 8 and data_out=0.
